debouncer_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-button debouncer. Used for the parking-counter sensors and push-buttons.
- Synchronises N asynchronous inputs, optionally inverts them, and filters each channel independently with a configurable stability window.
- Outputs a stable level vector plus one-cycle rise and fall pulses per channel, so downstream counters need no edge detector of their own.

---
 rtl/debouncer_multi.sv | 65 ++++++
 tb/tb_debouncer_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: synchronises N raw inputs, filters each channel with its
// own stability window, and emits the debounced level plus one-cycle rise/fall pulses.
module debouncer_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 100000,
  parameter int ACTIVE_LOW    = 0,
  parameter int INIT_LEVEL    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_stable,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [N_CH-1:0] POL_MASK = {N_CH{ACTIVE_LOW != 0}};
  localparam logic [N_CH-1:0] INIT_VEC = {N_CH{INIT_LEVEL != 0}};

  logic [N_CH-1:0]  sync1_p0;
  logic [N_CH-1:0]  sync2_p1;
  logic [N_CH-1:0]  cand_p2;
  logic [CNT_W-1:0] cnt_p2 [N_CH];

  // The window counter saturates here instead of wrapping, so a held input never re-fires.
  function automatic logic cnt_done(input logic [CNT_W-1:0] c);
    return c == CNT_MAX;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_p0   <= INIT_VEC;
      sync2_p1   <= INIT_VEC;
      cand_p2    <= INIT_VEC;
      btn_stable <= INIT_VEC;
      btn_rise   <= '0;
      btn_fall   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      // p0/p1: two-flop synchroniser with optional polarity flip
      sync1_p0 <= btn_in ^ POL_MASK;
      sync2_p1 <= sync1_p0;
      // p2: candidate tracking, stability window and registered level/pulses
      for (int i = 0; i < N_CH; i++) begin
        btn_rise[i] <= 1'b0;
        btn_fall[i] <= 1'b0;
        if (sync2_p1[i] != cand_p2[i]) begin
          cand_p2[i] <= sync2_p1[i];
          cnt_p2[i]  <= '0;
        end else if (!cnt_done(cnt_p2[i])) begin
          cnt_p2[i] <= cnt_p2[i] + 1'b1;
        end else begin
          btn_stable[i] <= cand_p2[i];
          btn_rise[i]   <= ~btn_stable[i] & cand_p2[i];
          btn_fall[i]   <= btn_stable[i] & ~cand_p2[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: three parameter sets share one stimulus stream; a per-cycle
// scoreboard from a run-length model plus a table of hand-derived segment expectations.
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = 4'h0;

  logic [3:0] a_st, a_rise, a_fall;
  logic [3:0] b_st, b_rise, b_fall;
  logic [3:0] c_st, c_rise, c_fall;

  debouncer_multi #(.N_CH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(0), .INIT_LEVEL(0)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_stable(a_st), .btn_rise(a_rise), .btn_fall(a_fall));

  debouncer_multi #(.N_CH(4), .STABLE_CYCLES(8), .ACTIVE_LOW(0), .INIT_LEVEL(0)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_stable(b_st), .btn_rise(b_rise), .btn_fall(b_fall));

  debouncer_multi #(.N_CH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(1), .INIT_LEVEL(1)) dut_c (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_stable(c_st), .btn_rise(c_rise), .btn_fall(c_fall));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: the input delayed three edges, plus the length of the run of equal
  // samples; the level is accepted once the run is long enough and still continuing.
  typedef struct packed {
    logic [3:0]      d1;
    logic [3:0]      d2;
    logic [3:0]      d3;
    logic [3:0][7:0] run;
    logic [3:0]      st;
    logic [3:0]      rise;
    logic [3:0]      fall;
  } mdl_t;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
  } exp_t;

  typedef struct packed {
    int         sel;
    logic       r;
    logic [3:0] b;
    int         n;
    int         pedge;
    logic [3:0] er;
    logic [3:0] ef;
    logic [3:0] est;
  } seg_t;

  mdl_t ma = '0;
  mdl_t mb = '0;
  mdl_t mc = '0;
  exp_t sbq[$];

  function automatic mdl_t mdl_next(input mdl_t m, input logic r, input logic [3:0] raw,
                                    input int s, input logic init, input logic al);
    mdl_t n;
    logic [3:0] x;
    n = m;
    x = raw ^ {4{al}};
    n.rise = '0;
    n.fall = '0;
    if (r) begin
      n.d1 = {4{init}};
      n.d2 = {4{init}};
      n.d3 = {4{init}};
      n.st = {4{init}};
      for (int c = 0; c < 4; c++) n.run[c] = 8'd1;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (int'(m.run[c]) >= s && m.d2[c] == m.d3[c] && m.st[c] != m.d3[c]) begin
          n.st[c]   = m.d3[c];
          n.rise[c] = m.d3[c];
          n.fall[c] = ~m.d3[c];
        end
        if (m.d2[c] == m.d3[c])
          n.run[c] = (m.run[c] == 8'd255) ? 8'd255 : m.run[c] + 8'd1;
        else
          n.run[c] = 8'd1;
      end
      n.d3 = m.d2;
      n.d2 = m.d1;
      n.d1 = x;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs(input int sel);
    case (sel)
      0:       return {a_st, a_rise, a_fall};
      1:       return {b_st, b_rise, b_fall};
      default: return {c_st, c_rise, c_fall};
    endcase
  endfunction

  // One clock: drive at the falling edge, predict, then compare just after the rising edge.
  task automatic step(input logic r, input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    rst    = r;
    btn_in = b;
    ma = mdl_next(ma, r, b, 4, 1'b0, 1'b0);
    mb = mdl_next(mb, r, b, 8, 1'b0, 1'b0);
    mc = mdl_next(mc, r, b, 4, 1'b1, 1'b1);
    sbq.push_back('{a: {ma.st, ma.rise, ma.fall},
                    b: {mb.st, mb.rise, mb.fall},
                    c: {mc.st, mc.rise, mc.fall}});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_a st/rise/fall", 32'(outs(0)), 32'(e.a));
    chk("sb_b st/rise/fall", 32'(outs(1)), 32'(e.b));
    chk("sb_c st/rise/fall", 32'(outs(2)), 32'(e.c));
  endtask

  // Hold one input pattern for n edges and check where the selected instance pulsed.
  task automatic hold(input int idx, input seg_t s);
    int          first  = 0;
    int          npulse = 0;
    logic [3:0]  got_r  = '0;
    logic [3:0]  got_f  = '0;
    logic [11:0] o;
    for (int e = 1; e <= s.n; e++) begin
      step(s.r, s.b);
      o = outs(s.sel);
      if ((o[7:4] | o[3:0]) != 4'h0) begin
        npulse++;
        if (first == 0) begin
          first = e;
          got_r = o[7:4];
          got_f = o[3:0];
        end
      end
    end
    o = outs(s.sel);
    chk($sformatf("seg%0d pulse_edge", idx), 32'(first), 32'(s.pedge));
    chk($sformatf("seg%0d pulse_count", idx), 32'(npulse), (s.pedge != 0) ? 32'd1 : 32'd0);
    chk($sformatf("seg%0d rise", idx), 32'(got_r), 32'(s.er));
    chk($sformatf("seg%0d fall", idx), 32'(got_f), 32'(s.ef));
    chk($sformatf("seg%0d stable", idx), 32'(o[11:8]), 32'(s.est));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_t tbl[$];
    // sel: 0 = STABLE_CYCLES 4, 1 = STABLE_CYCLES 8, 2 = active-low with INIT_LEVEL 1
    //            sel r     btn    n  edge rise   fall   stable
    tbl.push_back('{0, 1'b1, 4'hF,  2, 0, 4'h0, 4'h0, 4'h0});  // reset with inputs high
    tbl.push_back('{0, 1'b0, 4'hF,  9, 7, 4'hF, 4'h0, 4'hF});  // accepted at edge 7
    tbl.push_back('{0, 1'b0, 4'h0,  9, 7, 4'h0, 4'hF, 4'h0});
    tbl.push_back('{0, 1'b0, 4'h1,  9, 7, 4'h1, 4'h0, 4'h1});  // ch0 latency
    tbl.push_back('{0, 1'b0, 4'h0,  9, 7, 4'h0, 4'h1, 4'h0});
    tbl.push_back('{0, 1'b0, 4'h2,  3, 0, 4'h0, 4'h0, 4'h0});  // ch1 bounce train
    tbl.push_back('{0, 1'b0, 4'h0,  1, 0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{0, 1'b0, 4'h2,  2, 0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{0, 1'b0, 4'h0, 10, 0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{0, 1'b0, 4'h2,  8, 7, 4'h2, 4'h0, 4'h2});  // ch1 held high
    tbl.push_back('{0, 1'b0, 4'hF,  2, 0, 4'h0, 4'h0, 4'h2});  // ch0+ch3 rise, ch2 bounces
    tbl.push_back('{0, 1'b0, 4'hB,  1, 0, 4'h0, 4'h0, 4'h2});
    tbl.push_back('{0, 1'b0, 4'hF,  2, 0, 4'h0, 4'h0, 4'h2});
    tbl.push_back('{0, 1'b0, 4'hB,  8, 2, 4'h9, 4'h0, 4'hB});
    tbl.push_back('{0, 1'b0, 4'hF,  9, 7, 4'h4, 4'h0, 4'hF});  // ch2 finally holds
    tbl.push_back('{0, 1'b0, 4'h0, 12, 7, 4'h0, 4'hF, 4'h0});
    tbl.push_back('{1, 1'b0, 4'h0,  2, 0, 4'h0, 4'h0, 4'h0});  // long window settled low
    tbl.push_back('{1, 1'b0, 4'h1,  4, 0, 4'h0, 4'h0, 4'h0});  // window in progress
    tbl.push_back('{1, 1'b1, 4'h1,  1, 0, 4'h0, 4'h0, 4'h0});  // reset aborts it
    tbl.push_back('{1, 1'b0, 4'h1, 12, 11, 4'h1, 4'h0, 4'h1});
    tbl.push_back('{2, 1'b0, 4'hF,  9, 7, 4'h0, 4'hE, 4'h0});  // pins high read as low
    tbl.push_back('{2, 1'b0, 4'hB,  9, 7, 4'h4, 4'h0, 4'h4});  // pin 2 pulled low
    tbl.push_back('{2, 1'b0, 4'hB, 20, 0, 4'h0, 4'h0, 4'h4});  // holding: no repeats

    for (int i = 0; i < tbl.size(); i++) begin
      hold(i, tbl[i]);
    end

    // Active-low instance right after reset: inputs high read as 0 on every channel.
    step(1'b1, 4'hF);
    chk("c_reset_stable", 32'(c_st), 32'h0000_000F);
    chk("c_reset_pulses", 32'({c_rise, c_fall}), 32'h0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'hF);
      if (e == 6) chk("c_before_accept", 32'(c_st), 32'h0000_000F);
      if (e == 7) chk("c_fall_at_7", 32'(c_fall), 32'h0000_000F);
      if (e == 8) chk("c_fall_cleared", 32'({c_rise, c_fall}), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
